// File: rtl/da_output_stage.sv
// da_output_stage: merges the carry-save result of an upstream distributed-arithmetic stage,
// forms the error against the desired response and buffers {y, e} in a 2-entry FIFO.
//
// Ports:
//   clk        - sole clock, rising edge
//   r          - asynchronous active-low reset
//   t          - phase count shared with the upstream DA stage
//   sum, carry - carry-save result words (11-bit two's complement)
//   d          - desired-response sample (12-bit signed)
//   y, e       - merged output and error at the FIFO head
//   out_valid  - FIFO head is valid
//   out_ready  - consumer accepts the head
//   overflow   - sticky flag, set when a result is dropped on a full FIFO
//
// Optional feature: define DA_OUT_SAT_EN to saturate e to [-2048, 2047] instead of wrapping.
module da_output_stage #(
  parameter logic [2:0]  LAST_PHASE = 3'd4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        r,
  input  logic [2:0]  t,
  input  logic [10:0] sum,
  input  logic [10:0] carry,
  input  logic [11:0] d,
  output logic [11:0] y,
  output logic [11:0] e,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow
);

  // Capture stage
  logic        cap_vld_q;
  logic [10:0] sum_q, carry_q;
  logic [11:0] d_cap_q;

  // Merge stage
  logic        mrg_vld_q;
  logic [11:0] y_m_q, d_m_q;
  logic [11:0] y_m_d;

  // FIFO
  logic [11:0] fy_q [2];
  logic [11:0] fe_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  cnt_q, cnt_d;
  logic        ovf_q;

  logic [12:0] diff;
  logic [11:0] e_m;
  logic        push, pop, full, accept;

  // Merge is exact: two 11-bit operands never overflow 12 bits.
  assign y_m_d = {sum_q[10], sum_q} + {carry_q[10], carry_q};

  assign diff = {d_m_q[11], d_m_q} - {y_m_q[11], y_m_q};

`ifdef DA_OUT_SAT_EN
  // Out of 12-bit range exactly when the top two bits disagree.
  always_comb begin
    e_m = diff[11:0];
    if (diff[12] != diff[11]) begin
      e_m = diff[12] ? 12'h800 : 12'h7FF;
    end
  end
`else
  assign e_m = diff[11:0];
`endif

  assign push      = mrg_vld_q;
  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign full      = (cnt_q == FIFO_DEPTH[1:0]);
  // When full, a same-edge pop frees the slot being written.
  assign accept    = push && (!full || pop);

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!accept && pop) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      cap_vld_q <= 1'b0;
      sum_q     <= '0;
      carry_q   <= '0;
      d_cap_q   <= '0;
      mrg_vld_q <= 1'b0;
      y_m_q     <= '0;
      d_m_q     <= '0;
    end else begin
      cap_vld_q <= (t == LAST_PHASE);
      if (t == LAST_PHASE) begin
        sum_q   <= sum;
        carry_q <= carry;
        d_cap_q <= d;
      end
      mrg_vld_q <= cap_vld_q;
      if (cap_vld_q) begin
        y_m_q <= y_m_d;
        d_m_q <= d_cap_q;
      end
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      for (int i = 0; i < 2; i++) begin
        fy_q[i] <= '0;
        fe_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        fy_q[wr_ptr_q] <= y_m_q;
        fe_q[wr_ptr_q] <= e_m;
        wr_ptr_q       <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
      if (push && full && !pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign y        = fy_q[rd_ptr_q];
  assign e        = fe_q[rd_ptr_q];
  assign overflow = ovf_q;

endmodule

// File: tb/tb_da_output_stage.sv
module tb_da_output_stage;

  logic        clk = 1'b0;
  logic        r;
  logic [2:0]  t;
  logic [10:0] sum, carry;
  logic [11:0] d;
  logic [11:0] y, e;
  logic        out_valid, out_ready, overflow;

  always #5 clk = ~clk;

  da_output_stage #(
    .LAST_PHASE(3'd4),
    .FIFO_DEPTH(2)
  ) dut (
    .clk      (clk),
    .r        (r),
    .t        (t),
    .sum      (sum),
    .carry    (carry),
    .d        (d),
    .y        (y),
    .e        (e),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow (overflow)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    logic [23:0] v;
  } pend_t;

  typedef struct {
    logic [10:0] s;
    logic [10:0] c;
    logic [11:0] dd;
    logic [11:0] ey;
    logic [11:0] ee;
  } vec_t;

  // Reference model: results scheduled two edges after capture, then a queue capped at 2 entries.
  pend_t       pend[$];
  logic [23:0] fq[$];
  bit          m_ovf;

  function automatic logic [23:0] model_res(logic [10:0] s, logic [10:0] c, logic [11:0] dd);
    int yv, ev;
    yv = $signed(s) + $signed(c);
    ev = $signed(dd) - yv;
`ifdef DA_OUT_SAT_EN
    if (ev > 2047) ev = 2047;
    if (ev < -2048) ev = -2048;
`endif
    return {yv[11:0], ev[11:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    fq.delete();
    m_ovf = 1'b0;
  endtask

  // One clock edge: advance the model using pre-edge inputs, then compare #1 after the edge.
  task automatic step();
    bit          do_pop;
    bit          do_push;
    logic [23:0] pv;
    @(posedge clk);
    cyc++;
    do_pop  = (fq.size() != 0) && out_ready;
    do_push = 1'b0;
    pv      = '0;
    if (pend.size() != 0 && pend[0].due == cyc) begin
      do_push = 1'b1;
      pv      = pend[0].v;
      void'(pend.pop_front());
    end
    if (t == 3'd4) pend.push_back('{due: cyc + 2, v: model_res(sum, carry, d)});
    if (do_push && fq.size() == 2 && !do_pop) begin
      m_ovf = 1'b1;
    end else begin
      if (do_pop) void'(fq.pop_front());
      if (do_push) fq.push_back(pv);
    end
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, fq.size() != 0});
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    if (fq.size() != 0) begin
      check("y_head", {20'd0, y}, {20'd0, fq[0][23:12]});
      check("e_head", {20'd0, e}, {20'd0, fq[0][11:0]});
    end
  endtask

  task automatic capture(input logic [10:0] s, input logic [10:0] c, input logic [11:0] dd);
    t = 3'd4; sum = s; carry = c; d = dd;
    step();
    t = 3'd0;
  endtask

  task automatic do_reset();
    r = 1'b0;
    model_reset();
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", {20'd0, y}, 32'd0);
    check("rst_e", {20'd0, e}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    #2;
    r = 1'b1;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{s: 11'd100,  c: 11'd28,   dd: 12'd200,  ey: 12'd128,  ee: 12'd72};
    vecs[1] = '{s: 11'h7F0,  c: 11'h7F8,  dd: 12'd0,    ey: 12'hFE8,  ee: 12'd24};
`ifdef DA_OUT_SAT_EN
    vecs[2] = '{s: 11'h400,  c: 11'd0,    dd: 12'd2047, ey: 12'hC00,  ee: 12'h7FF};
    vecs[3] = '{s: 11'h3FF,  c: 11'h3FF,  dd: 12'h800,  ey: 12'h7FE,  ee: 12'h800};
`else
    vecs[2] = '{s: 11'h400,  c: 11'd0,    dd: 12'd2047, ey: 12'hC00,  ee: 12'hBFF};
    vecs[3] = '{s: 11'h3FF,  c: 11'h3FF,  dd: 12'h800,  ey: 12'h7FE,  ee: 12'h002};
`endif
    vecs[4] = '{s: 11'd0,    c: 11'd0,    dd: 12'd0,    ey: 12'd0,    ee: 12'd0};

    t = 3'd0; sum = '0; carry = '0; d = '0; out_ready = 1'b1; r = 1'b1;
    #2;
    do_reset();
    step();

    // Table vectors: capture, two edges later the head carries the result.
    foreach (vecs[i]) begin
      capture(vecs[i].s, vecs[i].c, vecs[i].dd);
      step();
      check("vec_valid_early", {31'd0, out_valid}, 32'd0);
      step();
      check("vec_valid", {31'd0, out_valid}, 32'd1);
      check("vec_y", {20'd0, y}, {20'd0, vecs[i].ey});
      check("vec_e", {20'd0, e}, {20'd0, vecs[i].ee});
      step();
      check("vec_popped", {31'd0, out_valid}, 32'd0);
    end

    // Backpressure: three results, third dropped.
    out_ready = 1'b0;
    capture(11'd1, 11'd0, 12'd0);
    step();
    capture(11'd2, 11'd0, 12'd0);
    step();
    capture(11'd3, 11'd0, 12'd0);
    step(); step(); step();
    check("bp_ovf", {31'd0, overflow}, 32'd1);
    check("bp_head_y", {20'd0, y}, 32'd1);
    check("bp_head_e", {20'd0, e}, 32'hFFF);
    step();
    check("bp_hold_y", {20'd0, y}, 32'd1);
    out_ready = 1'b1;
    step();
    check("bp_second_y", {20'd0, y}, 32'd2);
    step();
    check("bp_empty", {31'd0, out_valid}, 32'd0);
    check("bp_ovf_sticky", {31'd0, overflow}, 32'd1);

    // Simultaneous push and pop on a full FIFO.
    do_reset();
    out_ready = 1'b0;
    capture(11'd10, 11'd0, 12'd0);
    capture(11'd20, 11'd0, 12'd0);
    capture(11'd30, 11'd0, 12'd0);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("sim_ovf", {31'd0, overflow}, 32'd0);
    check("sim_head_y", {20'd0, y}, 32'd20);
    step();
    out_ready = 1'b1;
    step();
    check("sim_next_y", {20'd0, y}, 32'd30);
    step();
    check("sim_empty", {31'd0, out_valid}, 32'd0);

    // Reset mid-pipeline with an entry held at the head.
    out_ready = 1'b0;
    capture(11'd5, 11'd5, 12'd0);
    step(); step();
    check("mid_valid_before", {31'd0, out_valid}, 32'd1);
    capture(11'd7, 11'd0, 12'd0);
    #2;
    do_reset();
    for (int k = 0; k < 4; k++) step();
    check("mid_no_push", {31'd0, out_valid}, 32'd0);
    capture(11'd9, 11'd1, 12'd20);
    step(); step();
    check("mid_after_valid", {31'd0, out_valid}, 32'd1);
    check("mid_after_y", {20'd0, y}, 32'd10);
    check("mid_after_e", {20'd0, e}, 32'd10);

    // Randomized traffic against the model, including back-to-back capture phases.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      t         = ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
      sum       = 11'($urandom);
      carry     = 11'($urandom);
      d         = 12'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
